// File: rtl/tt_ctrl_drv_pkg.sv
// Shared definitions for the mux-controller selection sequencer: state encoding and
// default selection width (TT_SEL_W, shared with the controller's counter width).
`ifndef TT_SEL_W
`define TT_SEL_W 10
`endif

package tt_ctrl_drv_pkg;

  localparam int SEL_W_DFLT = `TT_SEL_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIS    = 3'd1,
    S_RST    = 3'd2,
    S_GAP    = 3'd3,
    S_INC_HI = 3'd4,
    S_INC_LO = 3'd5,
    S_ENA    = 3'd6
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tt_ctrl_drv_if.sv
// Request/status bundle between the harness (master) and the selection sequencer (slave).
interface tt_ctrl_drv_if
  import tt_ctrl_drv_pkg::*;
#(
  parameter int SEL_W = SEL_W_DFLT
) ();
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_sel;
  logic             req_ena;
  logic             done;
  logic             busy;
  logic [SEL_W-1:0] cur_sel;
  logic             cur_valid;

  modport master (
    output req_valid, req_sel, req_ena,
    input  req_ready, done, busy, cur_sel, cur_valid
  );

  modport slave (
    input  req_valid, req_sel, req_ena,
    output req_ready, done, busy, cur_sel, cur_valid
  );
endinterface

// File: rtl/tt_ctrl_drv_timer.sv
// Loadable phase down-counter; zero flags the last cycle of the current phase.
module tt_ctrl_drv_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/tt_ctrl_drv.sv
// Selection sequencer: reset pulse plus N increment pulses on the controller's select pins.
// Optional TT_CTRL_DRV_INCR_EN: skip the reset when the target is at or above the known count.
module tt_ctrl_drv
  import tt_ctrl_drv_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DFLT,
  parameter int RST_CYC = 4,
  parameter int HI_CYC  = 2,
  parameter int LO_CYC  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_ctrl_drv_if.slave  bus,
  output logic          ctrl_sel_rst_n,
  output logic          ctrl_sel_inc,
  output logic          ctrl_ena
);
  localparam int TMR_W = $clog2(max3(RST_CYC, HI_CYC, LO_CYC) + 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] rem, rem_load;
  logic [SEL_W-1:0] cur_sel_q;
  logic             cur_valid_q;
  logic             ena_l;
  logic             skip_l;
  logic             accept;
  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  assign accept        = (state == S_IDLE) && bus.req_valid;
  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_ENA);
  assign bus.cur_sel   = cur_sel_q;
  assign bus.cur_valid = cur_valid_q;

`ifdef TT_CTRL_DRV_INCR_EN
  logic skip_now;
  assign skip_now = cur_valid_q && (bus.req_sel >= cur_sel_q);
  assign rem_load = skip_now ? (bus.req_sel - cur_sel_q) : bus.req_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      skip_l <= 1'b0;
    else if (accept) skip_l <= skip_now;
  end
`else
  assign rem_load = bus.req_sel;
  assign skip_l   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.req_valid) state_nxt = S_DIS;
      S_DIS:    state_nxt = !skip_l ? S_RST : ((rem == '0) ? S_ENA : S_INC_HI);
      S_RST:    if (tmr_zero) state_nxt = S_GAP;
      S_GAP:    if (tmr_zero) state_nxt = (rem == '0) ? S_ENA : S_INC_HI;
      S_INC_HI: if (tmr_zero) state_nxt = S_INC_LO;
      S_INC_LO: if (tmr_zero) state_nxt = (rem == SEL_W'(1)) ? S_ENA : S_INC_HI;
      S_ENA:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Every state entry reloads the phase timer with (duration - 1).
  always_comb begin
    tmr_load = (state_nxt != state);
    tmr_val  = '0;
    case (state_nxt)
      S_RST:           tmr_val = TMR_W'(RST_CYC - 1);
      S_GAP, S_INC_LO: tmr_val = TMR_W'(LO_CYC - 1);
      S_INC_HI:        tmr_val = TMR_W'(HI_CYC - 1);
      default:         tmr_val = '0;
    endcase
  end

  tt_ctrl_drv_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Pin levels are decoded from the next state so they change together with the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rem            <= '0;
      ena_l          <= 1'b0;
      cur_sel_q      <= '0;
      cur_valid_q    <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state        <= state_nxt;
      ctrl_sel_inc <= (state_nxt == S_INC_HI);
      if (accept) begin
        ena_l <= bus.req_ena;
        rem   <= rem_load;
      end else if ((state == S_INC_LO) && tmr_zero) begin
        rem <= rem - SEL_W'(1);
      end
      if (state_nxt != state) begin
        case (state_nxt)
          S_DIS: begin
            ctrl_ena    <= 1'b0;
            cur_valid_q <= 1'b0;
          end
          S_RST: begin
            ctrl_sel_rst_n <= 1'b0;
            cur_sel_q      <= '0;
          end
          S_GAP:    ctrl_sel_rst_n <= 1'b1;
          S_INC_HI: cur_sel_q <= cur_sel_q + SEL_W'(1);
          S_ENA: begin
            ctrl_ena    <= ena_l;
            cur_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/tt_ctrl_drv.md
Name: tt_ctrl_drv

Overview:
- Initiator-side sequencer that drives the mux controller's three-wire selection interface: ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena.
- Takes a design-index request over a valid/ready handshake. Drives the controller's selection counter to that index with a reset pulse followed by N increment pulses, then optionally asserts ctrl_ena.
- Sits in the management/test harness on the other side of the pad-level control pins.
- Keeps a shadow copy of the controller's selection counter.

Parameters:
- SEL_W, 10: selection counter width; must match the controller counter width.
- RST_CYC, 4: clk cycles ctrl_sel_rst_n is held low per selection (min 1).
- HI_CYC, 2: clk cycles ctrl_sel_inc is high per increment pulse (min 1).
- LO_CYC, 2: clk cycles ctrl_sel_inc is low after each pulse and after reset release, for ripple settle (min 1).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: selection request valid.
- req_ready, output, 1: block can accept a request; high only in IDLE.
- req_sel, input, SEL_W: target design index.
- req_ena, input, 1: assert ctrl_ena after the selection completes.
- done, output, 1: one-cycle pulse when the sequence finishes.
- busy, output, 1: high in any state other than IDLE.
- cur_sel, output, SEL_W: shadow of the controller counter value.
- cur_valid, output, 1: shadow is known-good.
- ctrl_sel_rst_n, output, 1: counter reset to the controller, active low.
- ctrl_sel_inc, output, 1: increment clock to the controller; the count advances on its rising edge.
- ctrl_ena, output, 1: enable to the selected design.

Behaviour:
- Reset values: ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0, cur_sel=0, cur_valid=0, done=0, busy=0, req_ready=1, state=IDLE.
- After reset, ctrl_sel_rst_n stays 0 until the first request.
- All ctrl_* outputs are registered and glitch-free.
- Handshake: a request is accepted on a cycle with req_valid && req_ready. req_sel and req_ena are latched at that edge. req_valid while busy is ignored; it is not queued.
- FSM states: IDLE, DIS, RST, GAP, INC_HI, INC_LO, ENA.
- IDLE: on accept, go to DIS.
- DIS: 1 cycle; ctrl_ena=0; cur_valid=0. Then go to RST, or to INC_HI under the optional feature's skip path.
- RST: ctrl_sel_rst_n=0 for RST_CYC cycles; cur_sel is cleared to 0. Then go to GAP.
- GAP: ctrl_sel_rst_n=1 and ctrl_sel_inc=0 for LO_CYC cycles.
  - If remaining count = 0, go to ENA.
  - Otherwise go to INC_HI.
- INC_HI: ctrl_sel_inc=1 for HI_CYC cycles. cur_sel increments by 1 (mod 2^SEL_W) on entry. Then go to INC_LO.
- INC_LO: ctrl_sel_inc=0 for LO_CYC cycles. Remaining count decrements at the end.
  - Go to INC_HI if remaining > 0.
  - Otherwise go to ENA.
- ENA: 1 cycle. ctrl_ena=latched req_ena. cur_valid=1. done=1. Next state is IDLE.
- ctrl_ena holds its value in IDLE until the next accepted request.
- Remaining count is SEL_W bits, loaded with the latched target.
- Latency with no reset skip: 1+RST_CYC+LO_CYC+req_sel*(HI_CYC+LO_CYC)+1 cycles from accept to done. Example: req_sel=3 gives 1+4+2+12+1 = 20.
- Boundary cases:
  - req_sel=0: no inc pulses; latency 1+RST_CYC+LO_CYC+1.
  - req_sel=2^SEL_W-1: 1023 pulses, no wrap of cur_sel.
  - Async reset mid-sequence: all outputs return to reset values immediately. ctrl_sel_rst_n=0 forces the controller counter back to 0, which keeps it consistent with the shadow.
- A timer of ceil(log2(max(RST_CYC,HI_CYC,LO_CYC)+1)) bits is reloaded on every state entry.

Optional Feature:
- Macro: TT_CTRL_DRV_INCR_EN.
- When defined: in DIS, if cur_valid && req_sel >= cur_sel, skip RST and GAP. Remaining count becomes req_sel-cur_sel, and the next state is INC_HI, or ENA directly if the difference is 0.
  - This gives a fast re-select or an ena-only toggle.
  - If req_sel < cur_sel, the full reset path is used.
- When not defined: the full reset path is always used. The comparison and subtraction logic is absent.

Decomposition:
- Shared package/defs: the state encoding constants (IDLE..ENA, 3 bits) and the default SEL_W. SEL_W is tied to the same define as the controller counter width so the two cannot diverge.
- One natural sub-module: tt_ctrl_drv_timer, a loadable down-counter with a zero flag that times RST_CYC, HI_CYC and LO_CYC phases.

Test Plan:
- Post-reset, req_sel=5, req_ena=1:
  - rst_n low for 4 cycles, then 5 inc rising edges, each high 2 and low 2.
  - ctrl_ena=1 and done pulses at cycle 1+4+2+20+1=28.
  - cur_sel=5, cur_valid=1.
  - A behavioural model of the controller ripple counter reads 5.
- req_sel=0, req_ena=0:
  - rst pulse occurs, zero inc edges, ctrl_ena=0.
  - done at cycle 8, cur_sel=0.
- req_valid held high during busy with a different req_sel:
  - Ignored; req_ready=0 throughout.
  - After done, the held request is accepted on the first IDLE cycle.
- Async rst_n asserted during INC_HI of a req_sel=10 sequence:
  - ctrl_sel_rst_n=0, ctrl_inc=0, ctrl_ena=0, cur_valid=0 immediately; req_ready=1 after release.
- With TT_CTRL_DRV_INCR_EN, select 3, then 7:
  - Second sequence has no rst pulse, 4 inc pulses, cur_sel=7.
  - Then select 2: full rst path and 2 pulses.
- req_sel=1023: exactly 1023 inc edges, cur_sel=1023, and the controller model matches.
